// File: rtl/isa_camac_pkg.sv
// Shared constants for the ISA-to-CAMAC cycle controller: register map,
// STATUS bit layout, FSM encoding and bus widths.
package isa_camac_pkg;

  localparam int unsigned REG_W  = 2;
  localparam int unsigned ISA_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned F_W    = 5;
  localparam int unsigned A_W    = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [REG_W-1:0] REG_DATA_LO     = 2'd0;
  localparam logic [REG_W-1:0] REG_DATA_HI     = 2'd1;
  localparam logic [REG_W-1:0] REG_CMD         = 2'd2;
  localparam logic [REG_W-1:0] REG_ADDR_STATUS = 2'd3;

  localparam int unsigned STAT_BUSY    = 7;
  localparam int unsigned STAT_Q       = 6;
  localparam int unsigned STAT_X       = 5;
  localparam int unsigned STAT_DONE    = 4;
  localparam int unsigned STAT_OVERRUN = 3;

  // Functions 0..F_READ_MAX move dataway read lines into the data register.
  localparam logic [F_W-1:0] F_READ_MAX = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_S1    = 3'd2,
    S_GAP   = 3'd3,
    S_S2    = 3'd4,
    S_DONE  = 3'd5
  } cyc_state_e;

endpackage

// File: rtl/isa_camac_cycle_controller_isa_strobe_sync.sv
// Brings one asynchronous active-low ISA strobe into the clock domain and
// flags its falling edge.
module isa_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic fall_c,
  output logic level
);

  logic meta;
  logic sync;
  logic prev;

  // Strobes idle high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= strobe_n;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall_c = prev & ~sync;
  assign level  = sync;

endmodule

// File: rtl/isa_camac_cycle_controller.sv
// ISA-visible register block that runs one timed CAMAC dataway cycle
// (B, S1, S2) per write to the CMD register.
module isa_camac_cycle_controller
  import isa_camac_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned S1_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned S2_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [REG_W-1:0]  internal_address,
  input  logic              ior,
  input  logic              iow,
  input  logic [ISA_W-1:0]  isa_data_in,
  output logic [ISA_W-1:0]  isa_data_out,
  output logic              isa_data_oe,
  output logic [F_W-1:0]    camac_f,
  output logic [A_W-1:0]    camac_a,
  output logic [DATA_W-1:0] camac_wdata,
  input  logic [DATA_W-1:0] camac_rdata,
  input  logic              camac_q,
  input  logic              camac_x,
  output logic              camac_b,
  output logic              camac_s1,
  output logic              camac_s2,
  output logic              interrupt_req
);

  cyc_state_e         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               last_c, busy_c, b_c, s1_c, s2_c;
  logic               ior_fall_c, ior_level, iow_fall_c, iow_level_unused;
  logic               rd_acc_c, wr_acc_c, launch_c;
  logic [DATA_W-1:0]  data_q;
  logic [F_W-1:0]     f_q;
  logic [A_W-1:0]     a_q;
  logic               q_q, x_q, done_q, overrun_q;
  logic [ISA_W-1:0]   status_c, rd_mux_c;

  isa_strobe_sync u_ior_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_n (ior),
    .fall_c   (ior_fall_c),
    .level    (ior_level)
  );

  isa_strobe_sync u_iow_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_n (iow),
    .fall_c   (iow_fall_c),
    .level    (iow_level_unused)
  );

  assign rd_acc_c = ior_fall_c & sel;
  assign wr_acc_c = iow_fall_c & sel;
  assign busy_c   = (state != S_IDLE);
  assign launch_c = wr_acc_c & ~busy_c & (internal_address == REG_CMD);
  assign last_c   = (cnt == CNT_W'(1));

  function automatic logic [CNT_W-1:0] phase_len(input cyc_state_e s);
    case (s)
      S_SETUP: phase_len = CNT_W'(SETUP_CYCLES);
      S_S1:    phase_len = CNT_W'(S1_CYCLES);
      S_GAP:   phase_len = CNT_W'(GAP_CYCLES);
      S_S2:    phase_len = CNT_W'(S2_CYCLES);
      default: phase_len = CNT_W'(1);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state; the phase counter reloads on every state change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE:  if (launch_c) state_next = S_SETUP;
      S_SETUP: begin cnt_next = cnt - CNT_W'(1); if (last_c) state_next = S_S1;  end
      S_S1:    begin cnt_next = cnt - CNT_W'(1); if (last_c) state_next = S_GAP; end
      S_GAP:   begin cnt_next = cnt - CNT_W'(1); if (last_c) state_next = S_S2;  end
      S_S2:    begin cnt_next = cnt - CNT_W'(1); if (last_c) state_next = S_DONE; end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next != state) cnt_next = phase_len(state_next);
    b_c  = busy_c;
    s1_c = (state == S_S1);
    s2_c = (state == S_S2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      camac_b  <= 1'b0;
      camac_s1 <= 1'b0;
      camac_s2 <= 1'b0;
    end else begin
      camac_b  <= b_c;
      camac_s1 <= s1_c;
      camac_s2 <= s2_c;
    end
  end

  // Register file and status; sets are ordered after the STATUS-read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '0;
      f_q           <= '0;
      a_q           <= '0;
      q_q           <= 1'b0;
      x_q           <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      interrupt_req <= 1'b0;
    end else begin
      if (rd_acc_c && internal_address == REG_ADDR_STATUS) begin
        done_q        <= 1'b0;
        overrun_q     <= 1'b0;
        interrupt_req <= 1'b0;
      end
      if (wr_acc_c) begin
        if (busy_c) begin
          overrun_q <= 1'b1;
        end else begin
          case (internal_address)
            REG_DATA_LO:     data_q[7:0]  <= isa_data_in;
            REG_DATA_HI:     data_q[15:8] <= isa_data_in;
            REG_CMD:         f_q          <= isa_data_in[F_W-1:0];
            REG_ADDR_STATUS: a_q          <= isa_data_in[A_W-1:0];
          endcase
        end
      end
      if (state == S_S1 && last_c) begin
        q_q <= camac_q;
        x_q <= camac_x;
        if (f_q <= F_READ_MAX) data_q <= camac_rdata;
      end
      if (state == S_DONE) begin
        done_q        <= 1'b1;
        interrupt_req <= 1'b1;
      end
    end
  end

  always_comb begin
    status_c               = '0;
    status_c[STAT_BUSY]    = busy_c;
    status_c[STAT_Q]       = q_q;
    status_c[STAT_X]       = x_q;
    status_c[STAT_DONE]    = done_q;
    status_c[STAT_OVERRUN] = overrun_q;
    rd_mux_c               = '0;
    case (internal_address)
      REG_DATA_LO:     rd_mux_c = data_q[7:0];
      REG_DATA_HI:     rd_mux_c = data_q[15:8];
      REG_CMD:         rd_mux_c = {3'b000, f_q};
      REG_ADDR_STATUS: rd_mux_c = status_c;
    endcase
  end

  // Read data is frozen at acceptance; drive ends once ior is seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      isa_data_out <= '0;
      isa_data_oe  <= 1'b0;
    end else if (rd_acc_c) begin
      isa_data_out <= rd_mux_c;
      isa_data_oe  <= 1'b1;
    end else if (ior_level) begin
      isa_data_oe  <= 1'b0;
    end
  end

  assign camac_f     = f_q;
  assign camac_a     = a_q;
  assign camac_wdata = data_q;

endmodule

// File: tb/tb_isa_camac_cycle_controller.sv
// Directed self-checking bench for isa_camac_cycle_controller with default
// timing parameters.
module tb_isa_camac_cycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [1:0]  internal_address;
  logic        ior;
  logic        iow;
  logic [7:0]  isa_data_in;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe;
  logic [4:0]  camac_f;
  logic [3:0]  camac_a;
  logic [15:0] camac_wdata;
  logic [15:0] camac_rdata;
  logic        camac_q;
  logic        camac_x;
  logic        camac_b;
  logic        camac_s1;
  logic        camac_s2;
  logic        interrupt_req;

  int checks   = 0;
  int failures = 0;

  isa_camac_cycle_controller dut (
    .clk              (clk),
    .rst              (rst),
    .sel              (sel),
    .internal_address (internal_address),
    .ior              (ior),
    .iow              (iow),
    .isa_data_in      (isa_data_in),
    .isa_data_out     (isa_data_out),
    .isa_data_oe      (isa_data_oe),
    .camac_f          (camac_f),
    .camac_a          (camac_a),
    .camac_wdata      (camac_wdata),
    .camac_rdata      (camac_rdata),
    .camac_q          (camac_q),
    .camac_x          (camac_x),
    .camac_b          (camac_b),
    .camac_s1         (camac_s1),
    .camac_s2         (camac_s2),
    .interrupt_req    (interrupt_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic isa_write(input logic s, input logic [1:0] ad, input logic [7:0] d);
    @(negedge clk);
    sel = s; internal_address = ad; isa_data_in = d; iow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    iow = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b1;
  endtask

  task automatic isa_read(input logic [1:0] ad, output logic [7:0] d,
                          output logic oe_before, output logic oe_during,
                          output logic oe_after);
    @(negedge clk);
    oe_before = isa_data_oe;
    sel = 1'b1; internal_address = ad; ior = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    d = isa_data_out;
    oe_during = isa_data_oe;
    ior = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    oe_after = isa_data_oe;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!camac_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; internal_address = 2'd0; ior = 1'b1; iow = 1'b1;
    isa_data_in = 8'h00; camac_rdata = 16'h0000; camac_q = 1'b0; camac_x = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({isa_data_out, isa_data_oe, camac_f, camac_a} !== 18'h0) begin
      failures++;
      $display("FAIL reset_isa_fa got=%h want=0", {isa_data_out, isa_data_oe, camac_f, camac_a});
    end
    checks++;
    if ({camac_wdata, camac_b, camac_s1, camac_s2, interrupt_req} !== 20'h0) begin
      failures++;
      $display("FAIL reset_camac got=%h want=0", {camac_wdata, camac_b, camac_s1, camac_s2, interrupt_req});
    end
    rst = 1'b0;
  endtask

  task automatic test_register_round_trip;
    logic [7:0] d;
    logic ob, od, oa;
    isa_write(1'b1, 2'd0, 8'h5A);
    isa_write(1'b1, 2'd1, 8'hC3);
    isa_read(2'd0, d, ob, od, oa);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL rt_data_lo got=%h want=5a", d); end
    checks++;
    if ({ob, od, oa} !== 3'b010) begin failures++; $display("FAIL rt_oe_lo got=%b want=010", {ob, od, oa}); end
    isa_read(2'd1, d, ob, od, oa);
    checks++;
    if (d !== 8'hC3) begin failures++; $display("FAIL rt_data_hi got=%h want=c3", d); end
    checks++;
    if ({ob, od, oa} !== 3'b010) begin failures++; $display("FAIL rt_oe_hi got=%b want=010", {ob, od, oa}); end
  endtask

  task automatic test_write_cycle;
    logic [30:0] act_b, act_s1, act_s2, act_irq, exp_b, exp_s1, exp_s2, exp_irq;
    logic bad_faw;
    bad_faw = 1'b0;
    isa_write(1'b1, 2'd3, 8'h03);
    @(negedge clk);
    sel = 1'b1; internal_address = 2'd2; isa_data_in = 8'h10; iow = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      if (k == 0) iow = 1'b1;
      act_b[k]   = camac_b;
      act_s1[k]  = camac_s1;
      act_s2[k]  = camac_s2;
      act_irq[k] = interrupt_req;
      exp_b[k]   = (k >= 1)  && (k <= 25);
      exp_s1[k]  = (k >= 5)  && (k <= 12);
      exp_s2[k]  = (k >= 17) && (k <= 24);
      exp_irq[k] = (k >= 25);
      if (camac_f !== 5'd16 || camac_a !== 4'd3 || camac_wdata !== 16'hC35A) bad_faw = 1'b1;
    end
    checks++;
    if (act_b !== exp_b) begin failures++; $display("FAIL wc_b got=%b want=%b", act_b, exp_b); end
    checks++;
    if (act_s1 !== exp_s1) begin failures++; $display("FAIL wc_s1 got=%b want=%b", act_s1, exp_s1); end
    checks++;
    if (act_s2 !== exp_s2) begin failures++; $display("FAIL wc_s2 got=%b want=%b", act_s2, exp_s2); end
    checks++;
    if (act_irq !== exp_irq) begin failures++; $display("FAIL wc_irq got=%b want=%b", act_irq, exp_irq); end
    checks++;
    if (bad_faw !== 1'b0) begin
      failures++;
      $display("FAIL wc_f_a_wdata got f=%h a=%h w=%h want f=10 a=3 w=c35a", camac_f, camac_a, camac_wdata);
    end
  endtask

  task automatic test_read_cycle;
    logic [7:0] d;
    logic ob, od, oa, ok;
    camac_rdata = 16'h1234; camac_q = 1'b1; camac_x = 1'b1;
    isa_write(1'b1, 2'd2, 8'h00);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL rc_timeout got=busy want=idle"); end
    isa_read(2'd0, d, ob, od, oa);
    checks++;
    if (d !== 8'h34) begin failures++; $display("FAIL rc_data_lo got=%h want=34", d); end
    isa_read(2'd1, d, ob, od, oa);
    checks++;
    if (d !== 8'h12) begin failures++; $display("FAIL rc_data_hi got=%h want=12", d); end
    isa_read(2'd3, d, ob, od, oa);
    checks++;
    if (d !== 8'h70) begin failures++; $display("FAIL rc_status1 got=%h want=70", d); end
    isa_read(2'd3, d, ob, od, oa);
    checks++;
    if (d !== 8'h60) begin failures++; $display("FAIL rc_status2 got=%h want=60", d); end
    checks++;
    if (interrupt_req !== 1'b0) begin failures++; $display("FAIL rc_irq_clear got=%b want=0", interrupt_req); end
  endtask

  task automatic test_write_while_busy;
    logic [7:0] d;
    logic ob, od, oa, ok;
    isa_write(1'b1, 2'd2, 8'h10);
    isa_write(1'b1, 2'd0, 8'hFF);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL wb_timeout got=busy want=idle"); end
    isa_read(2'd0, d, ob, od, oa);
    checks++;
    if (d !== 8'h34) begin failures++; $display("FAIL wb_data_lo got=%h want=34", d); end
    isa_read(2'd3, d, ob, od, oa);
    checks++;
    if (d !== 8'h78) begin failures++; $display("FAIL wb_status got=%h want=78", d); end
    isa_read(2'd3, d, ob, od, oa);
    checks++;
    if (d !== 8'h60) begin failures++; $display("FAIL wb_status_clear got=%h want=60", d); end
  endtask

  task automatic test_not_selected;
    logic [7:0] d;
    logic ob, od, oa, saw_b;
    saw_b = 1'b0;
    isa_write(1'b0, 2'd2, 8'h01);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (camac_b !== 1'b0) saw_b = 1'b1;
    end
    checks++;
    if (saw_b !== 1'b0) begin failures++; $display("FAIL ns_b got=1 want=0"); end
    isa_read(2'd2, d, ob, od, oa);
    checks++;
    if (d !== 8'h10) begin failures++; $display("FAIL ns_cmd got=%h want=10", d); end
  endtask

  task automatic test_reset_mid_cycle;
    logic [7:0] d;
    logic ob, od, oa, seen;
    seen = 1'b0;
    isa_write(1'b1, 2'd2, 8'h10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (camac_s1) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL rm_s1_seen got=0 want=1"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({camac_s1, camac_s2, camac_b, interrupt_req} !== 4'b0000) begin
      failures++;
      $display("FAIL rm_strobes got=%b want=0000", {camac_s1, camac_s2, camac_b, interrupt_req});
    end
    checks++;
    if ({camac_f, camac_a, camac_wdata} !== 25'h0) begin
      failures++;
      $display("FAIL rm_regs got=%h want=0", {camac_f, camac_a, camac_wdata});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      isa_read(2'(r), d, ob, od, oa);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL rm_reg%0d got=%h want=00", r, d); end
    end
  endtask

  initial begin
    test_reset;
    test_register_round_trip;
    test_write_cycle;
    test_read_cycle;
    test_write_while_busy;
    test_not_selected;
    test_reset_mid_cycle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
